// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate data cache.
// Hits are served in COMPARE with no stall; misses write back then refill a 4-word line.
module dcache_direct_wb #(
    parameter int NUM_INDEX_BIT = 3,
    parameter int TAG_W         = 30 - NUM_INDEX_BIT - 2
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int NUM_LINES = 1 << NUM_INDEX_BIT;

    typedef enum logic [1:0] {
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         line_q [NUM_LINES];

    logic [TAG_W-1:0]         req_tag;
    logic [NUM_INDEX_BIT-1:0] idx;
    logic [1:0]               ofs;
    logic [127:0]             cur_line;
    logic [31:0]              cur_word;
    logic                     hit;
    logic                     req;
    logic                     do_fill;
    logic                     do_write;

    assign req_tag  = proc_addr[29:2+NUM_INDEX_BIT];
    assign idx      = proc_addr[1+NUM_INDEX_BIT:2];
    assign ofs      = proc_addr[1:0];
    assign cur_line = line_q[idx];
    assign cur_word = cur_line[{ofs, 5'b0} +: 32];
    assign hit      = valid[idx] && (tag_q[idx] == req_tag);
    assign req      = proc_read || proc_write;

    // Reset wins over any same-cycle array update.
    assign do_fill  = (state == ALLOCATE) && mem_ready && !proc_reset;
    assign do_write = (state == COMPARE) && proc_write && hit && !proc_reset;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= COMPARE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COMPARE: begin
                if (req && !hit) begin
                    state_nxt = dirty[idx] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_nxt = COMPARE;
                end
            end
            default: state_nxt = COMPARE;
        endcase
    end

    always_comb begin
        proc_rdata = '0;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            COMPARE: begin
                proc_stall = req && !hit;
                if (proc_read && !proc_write && hit) begin
                    proc_rdata = cur_word;
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = cur_line;
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (do_fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (do_write) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tags and line data are left untouched by reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[idx]  <= req_tag;
            line_q[idx] <= mem_rdata;
        end else if (do_write) begin
            line_q[idx][{ofs, 5'b0} +: 32] <= proc_wdata;
        end
    end

endmodule
